// File: rtl/imm_encoder.sv
// Inverse immediate extender: maps a 32-bit constant and ImmSrc-style mode to
// Instruction[23:0], or flags it as unencodable. Rotated immediates are searched iteratively.
module imm_encoder #(
  parameter int unsigned ROTS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_mode,
  input  logic [31:0] in_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_fits,
  output logic [23:0] out_field
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] value_q, value_d;
  logic [3:0]  rot_q, rot_d;
  logic        out_valid_q, out_valid_d;
  logic        out_fits_q, out_fits_d;
  logic [23:0] out_field_q, out_field_d;

  logic        hit;
  logic [3:0]  hit_rot;
  logic [7:0]  hit_imm;
  logic        last_batch;

  // Left rotation by 2*r: upper half of the doubled word shifted left.
  function automatic logic [31:0] rotl2(input logic [31:0] v, input logic [3:0] r);
    logic [63:0] dbl;
    dbl = {v, v} << {r, 1'b0};
    return dbl[63:32];
  endfunction

  // Tests this cycle's batch of rotations; the lowest hitting rotation wins.
  always_comb begin : search
    logic [3:0]  r;
    logic [31:0] cand;
    hit     = 1'b0;
    hit_rot = '0;
    hit_imm = '0;
    r       = '0;
    cand    = '0;
    for (int unsigned i = 0; i < ROTS_PER_CYCLE; i++) begin
      r    = rot_q + 4'(i);
      cand = rotl2(value_q, r);
      if (!hit && cand[31:8] == '0) begin
        hit     = 1'b1;
        hit_rot = r;
        hit_imm = cand[7:0];
      end
    end
  end

  assign last_batch = ({1'b0, rot_q} + 5'(ROTS_PER_CYCLE)) == 5'd16;

  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    rot_d       = rot_q;
    out_valid_d = out_valid_q;
    out_fits_d  = out_fits_q;
    out_field_d = out_field_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          value_d = in_value;
          rot_d   = '0;
          unique case (in_mode)
            2'b00: state_d = SEARCH;
            2'b01: begin
              state_d     = DONE;
              out_valid_d = 1'b1;
              out_fits_d  = (in_value[31:12] == '0);
              out_field_d = (in_value[31:12] == '0) ? {12'b0, in_value[11:0]} : '0;
            end
            2'b10: begin
              state_d     = DONE;
              out_valid_d = 1'b1;
              out_fits_d  = (in_value[1:0] == '0) && (in_value[31:26] == {6{in_value[25]}});
              out_field_d = ((in_value[1:0] == '0) && (in_value[31:26] == {6{in_value[25]}}))
                            ? in_value[25:2] : '0;
            end
            default: begin
              state_d     = DONE;
              out_valid_d = 1'b1;
              out_fits_d  = 1'b0;
              out_field_d = '0;
            end
          endcase
        end
      end
      SEARCH: begin
        if (hit) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_fits_d  = 1'b1;
          out_field_d = {12'b0, hit_rot, hit_imm};
        end else if (last_batch) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_fits_d  = 1'b0;
          out_field_d = '0;
        end else begin
          rot_d = rot_q + 4'(ROTS_PER_CYCLE);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          rot_d       = '0;
          out_valid_d = 1'b0;
          out_fits_d  = 1'b0;
          out_field_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      value_q     <= '0;
      rot_q       <= '0;
      out_valid_q <= 1'b0;
      out_fits_q  <= 1'b0;
      out_field_q <= '0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      rot_q       <= rot_d;
      out_valid_q <= out_valid_d;
      out_fits_q  <= out_fits_d;
      out_field_q <= out_field_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_fits  = out_fits_q;
  assign out_field = out_field_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: three instances (1, 2, 4 rotations per cycle)
// share stimulus; per-instance monitors compare results and search latency against a model.
module tb_imm_encoder;

  typedef struct {
    logic        fits;
    logic [23:0] field;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sbq [3][$];
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_mode = '0;
  logic [31:0] in_value = '0;
  logic [2:0]  in_ready_v, out_valid_v, out_fits_v, field_nz_v;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] rotl_m(input logic [31:0] v, input int s);
    if (s == 0) return v;
    return (v << s) | (v >> (32 - s));
  endfunction

  // Reference: encodability decided from the numeric rules of each mode.
  task automatic model(input logic [1:0] m, input logic [31:0] v,
                       output logic fits, output logic [23:0] field, output int rot);
    int s;
    logic [31:0] c;
    fits = 1'b0; field = '0; rot = -1;
    case (m)
      2'd0: begin
        for (int k = 0; k < 16; k++) begin
          c = rotl_m(v, 2 * k);
          if (c < 256) begin
            fits = 1'b1; field = 24'(k * 256 + int'(c)); rot = k;
            break;
          end
        end
      end
      2'd1: begin
        fits  = (v < 32'd4096);
        field = fits ? 24'(v) : '0;
      end
      2'd2: begin
        s     = int'(v);
        fits  = (s % 4 == 0) && (s >= -33554432) && (s <= 33554431);
        field = fits ? 24'(s >>> 2) : '0;
      end
      default: ;
    endcase
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : gen_dut
    localparam int unsigned N = 1 << gi;
    logic        rdy, vld, fits, ordy;
    logic [23:0] field;

    imm_encoder #(.ROTS_PER_CYCLE(N)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (rdy),
      .in_mode   (in_mode),
      .in_value  (in_value),
      .out_valid (vld),
      .out_ready (ordy),
      .out_fits  (fits),
      .out_field (field)
    );

    assign in_ready_v[gi]  = rdy;
    assign out_valid_v[gi] = vld;
    assign out_fits_v[gi]  = fits;
    assign field_nz_v[gi]  = |field;

    initial begin : mon
      exp_t        e;
      int          h;
      logic        sfit;
      logic [23:0] sfield;
      ordy = 1'b0;
      @(posedge reset_n);
      forever begin
        @(posedge clk); #1;
        if (reset_n && vld) begin
          if (sbq[gi].size() == 0) begin
            chk($sformatf("N%0d unexpected out_valid", N), 32'(vld), 32'd0);
          end else begin
            e = sbq[gi].pop_front();
            chk($sformatf("N%0d fits", N), 32'(fits), 32'(e.fits));
            chk($sformatf("N%0d field", N), 32'(field), 32'(e.field));
            if (e.lat >= 0) chk($sformatf("N%0d latency", N), 32'(cyc - e.acc), 32'(e.lat));
          end
          h = $urandom_range(0, 3);
          sfit = fits; sfield = field;
          repeat (h) begin
            @(posedge clk); #1;
            chk($sformatf("N%0d hold valid", N), 32'(vld), 32'd1);
            chk($sformatf("N%0d hold fits", N), 32'(fits), 32'(sfit));
            chk($sformatf("N%0d hold field", N), 32'(field), 32'(sfield));
            chk($sformatf("N%0d hold in_ready", N), 32'(rdy), 32'd0);
          end
          ordy = 1'b1;
          @(posedge clk); #1;
          ordy = 1'b0;
          chk($sformatf("N%0d handoff valid", N), 32'(vld), 32'd0);
          chk($sformatf("N%0d handoff in_ready", N), 32'(rdy), 32'd1);
          chk($sformatf("N%0d handoff clear", N), {7'b0, fits, field}, 32'd0);
        end
      end
    end
  end

  task automatic wait_idle(input string nm);
    int t = 0;
    while (in_ready_v !== 3'b111 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 200) chk({nm, " in_ready timeout"}, {29'b0, in_ready_v}, 32'd7);
  endtask

  task automatic send(input logic [1:0] m, input logic [31:0] v);
    exp_t e;
    int   r;
    int   n;
    wait_idle("send");
    model(m, v, e.fits, e.field, r);
    for (int i = 0; i < 3; i++) begin
      n     = 1 << i;
      e.acc = cyc + 1;
      if (m == 2'd0) e.lat = e.fits ? (r + n) / n : 16 / n;
      else           e.lat = -1;
      sbq[i].push_back(e);
    end
    in_mode = m; in_value = v; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin : drv
    logic [1:0]  m;
    logic [31:0] v;
    int          s;
    int          t;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", {29'b0, in_ready_v}, 32'd7);
    chk("reset out_valid", {29'b0, out_valid_v}, 32'd0);
    chk("reset out_fits", {29'b0, out_fits_v}, 32'd0);
    chk("reset out_field", {29'b0, field_nz_v}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    send(2'd0, 32'h0000_00FF);
    send(2'd0, 32'hFF00_0000);
    send(2'd0, 32'h0000_03FC);
    send(2'd0, 32'h0000_0000);
    send(2'd0, 32'h0000_0101);
    send(2'd2, 32'hFFFF_FFF8);
    send(2'd2, 32'h0200_0000);
    send(2'd2, 32'h0000_0006);
    send(2'd1, 32'h0000_0FFF);
    send(2'd1, 32'h0000_1000);
    send(2'd3, 32'h0000_1234);

    // Abort a search with reset: no result may appear afterwards.
    wait_idle("abort");
    in_mode = 2'd0; in_value = 32'h0000_0101; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("busy in_ready", {29'b0, in_ready_v}, 32'd0);
    reset_n = 1'b0;
    #1;
    chk("abort in_ready", {29'b0, in_ready_v}, 32'd7);
    chk("abort out_valid", {29'b0, out_valid_v}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("release in_ready", {29'b0, in_ready_v}, 32'd7);
    chk("release out_valid", {29'b0, out_valid_v}, 32'd0);

    for (int k = 0; k < 80; k++) begin
      m = 2'($urandom_range(0, 3));
      case (m)
        2'd0: v = ($urandom_range(0, 1) == 1)
                  ? rotl_m(32'($urandom_range(0, 255)), 2 * int'($urandom_range(0, 15)))
                  : $urandom;
        2'd1: v = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 8191)) : $urandom;
        2'd2: begin
          s = int'($urandom_range(0, 32'h07FF_FFFF)) - 32'h0400_0000;
          if ($urandom_range(0, 1) == 1) s = s & ~3;
          v = 32'(s);
        end
        default: v = $urandom;
      endcase
      send(m, v);
    end

    t = 0;
    while ((in_ready_v !== 3'b111 || sbq[0].size() + sbq[1].size() + sbq[2].size() != 0)
           && t < 500) begin
      @(posedge clk); #1; t++;
    end
    chk("drain leftover", 32'(sbq[0].size() + sbq[1].size() + sbq[2].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
